// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 key-matrix scanner: matrix geometry, key indices,
// scan FSM encoding and a small bit-count helper.
package teclado_pkg;

   localparam int N_LINHAS  = 4;
   localparam int N_COLUNAS = 4;
   localparam int N_TECLAS  = N_LINHAS * N_COLUNAS;
   localparam int N_NOTAS   = 13;

   localparam int KEY_LEFT  = 13;
   localparam int KEY_RIGHT = 14;
   localparam int KEY_ENTER = 15;

   typedef enum logic [1:0] {
      INICIO  = 2'd0,
      VARRE   = 2'd1,
      PUBLICA = 2'd2
   } estado_t;

   function automatic logic [3:0] conta_bits(input logic [N_NOTAS-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < N_NOTAS; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL so an
// idle (pulled-up) input reads as released right after reset.
import teclado_pkg::*;

module sincronizador_2ff #(
   parameter int              SIZE      = 4,
   parameter logic [SIZE-1:0] RESET_VAL = '1
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic [SIZE-1:0] i_async,
   output logic [SIZE-1:0] o_sync
);

   logic [SIZE-1:0] r_meta;
   logic [SIZE-1:0] r_sync;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/varredor_teclado.sv
// 4x4 key-matrix scanner: drives one column at a time, samples the synchronized rows
// into a shadow snapshot and publishes the whole frame at once on registered outputs.
//
// state   | meaning
// INICIO  | one idle cycle after reset, all columns released
// VARRE   | column r_coluna driven low for DWELL_CYCLES cycles, rows sampled once
// PUBLICA | one cycle, columns released, snapshot visible with o_varredura_fim=1
import teclado_pkg::*;

module varredor_teclado #(
   parameter int DWELL_CYCLES  = 50_000,
   parameter int SETTLE_CYCLES = 32
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic [3:0]    i_linhas,
   output logic [3:0]    o_colunas,
   output logic [12:0]   o_botoes,
   output logic          o_left_arrow_pressed,
   output logic          o_right_arrow_pressed,
   output logic          o_enter_pressed,
   output logic          o_multi_nota,
   output logic          o_varredura_fim,
   output logic [1:0]    o_db_coluna
);

   localparam int              DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [DW-1:0]   SETTLE_IDX = DW'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > DWELL_CYCLES - 1) begin : g_settle_invalido
      $error("SETTLE_CYCLES must lie in 3..DWELL_CYCLES-1");
   end

   estado_t             r_estado;
   estado_t             w_prox_estado;
   logic [DW-1:0]       r_dwell;
   logic [DW-1:0]       w_prox_dwell;
   logic [1:0]          r_coluna;
   logic [1:0]          w_prox_coluna;
   logic [3:0]          r_colunas;
   logic [3:0]          w_prox_colunas;
   logic                w_fim_dwell;
   logic                w_amostra;
   logic                w_publica;
   logic [3:0]          w_linhas_sync;
   logic [N_TECLAS-1:0] r_shadow;

   logic [N_NOTAS-1:0]  r_botoes;
   logic                r_left;
   logic                r_right;
   logic                r_enter;
   logic                r_multi;
   logic                r_fim;

   sincronizador_2ff #(
      .SIZE      (N_LINHAS),
      .RESET_VAL (4'b1111)
   ) u_sync_linhas (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (i_linhas),
      .o_sync  (w_linhas_sync)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_estado  <= INICIO;
         r_dwell   <= '0;
         r_coluna  <= 2'd0;
         r_colunas <= 4'b1111;
      end else begin
         r_estado  <= w_prox_estado;
         r_dwell   <= w_prox_dwell;
         r_coluna  <= w_prox_coluna;
         r_colunas <= w_prox_colunas;
      end
   end

   // Column drive is registered from the next-state values so the matrix lines
   // never see decode glitches while still following the state cycle-for-cycle.
   always_comb begin
      w_prox_estado  = r_estado;
      w_prox_dwell   = '0;
      w_prox_coluna  = 2'd0;
      w_fim_dwell    = (r_dwell == DWELL_LAST);
      w_amostra      = 1'b0;
      w_publica      = 1'b0;
      case (r_estado)
         INICIO: begin
            w_prox_estado = VARRE;
         end
         VARRE: begin
            w_amostra     = (r_dwell == SETTLE_IDX);
            w_prox_coluna = r_coluna;
            if (w_fim_dwell) begin
               if (r_coluna == 2'd3) begin
                  w_prox_estado = PUBLICA;
                  w_publica     = 1'b1;
               end else begin
                  w_prox_coluna = r_coluna + 2'd1;
               end
            end else begin
               w_prox_dwell = r_dwell + DW'(1);
            end
         end
         PUBLICA: begin
            w_prox_estado = VARRE;
         end
         default: begin
            w_prox_estado = INICIO;
         end
      endcase
      w_prox_colunas = (w_prox_estado == VARRE) ? ~(4'b0001 << w_prox_coluna) : 4'b1111;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_shadow <= '0;
      end else if (w_amostra) begin
         r_shadow[{r_coluna, 2'b00} +: N_LINHAS] <= ~w_linhas_sync;
      end
   end

   // The last column is sampled well before the dwell ends, so the snapshot is
   // complete on the edge entering PUBLICA and appears together with the pulse.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_botoes <= '0;
         r_left   <= 1'b0;
         r_right  <= 1'b0;
         r_enter  <= 1'b0;
         r_multi  <= 1'b0;
         r_fim    <= 1'b0;
      end else begin
         r_fim <= w_publica;
         if (w_publica) begin
            r_botoes <= r_shadow[N_NOTAS-1:0];
            r_left   <= r_shadow[KEY_LEFT];
            r_right  <= r_shadow[KEY_RIGHT];
            r_enter  <= r_shadow[KEY_ENTER];
            r_multi  <= (conta_bits(r_shadow[N_NOTAS-1:0]) > 4'd1);
         end
      end
   end

   assign o_colunas             = r_colunas;
   assign o_botoes              = r_botoes;
   assign o_left_arrow_pressed  = r_left;
   assign o_right_arrow_pressed = r_right;
   assign o_enter_pressed       = r_enter;
   assign o_multi_nota          = r_multi;
   assign o_varredura_fim       = r_fim;
   assign o_db_coluna           = r_coluna;

endmodule

// File: tb/tb_varredor_teclado.sv
// Scoreboard bench for varredor_teclado: a behavioural key matrix, a table of held-key
// frames with hand-computed snapshots, and a monitor that checks every publish pulse.
module tb_varredor_teclado;

   localparam int DWELL  = 8;
   localparam int SETTLE = 4;
   localparam int FRAME  = 4 * DWELL + 1;
   localparam int NF     = 10;

   typedef struct packed {
      logic [12:0] b;
      logic        l;
      logic        r;
      logic        e;
      logic        m;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  linhas;
   logic [3:0]  colunas;
   logic [12:0] botoes;
   logic        left_p, right_p, enter_p, multi, fim;
   logic [1:0]  db_col;

   logic [15:0] held = 16'h0000;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;

   logic [15:0] t_mask [NF] = '{16'h0020, 16'h0020, 16'h1001, 16'hE000, 16'h0080,
                                16'h0080, 16'h0000, 16'h0118, 16'h1000, 16'h3000};
   exp_t        t_exp  [NF] = '{
      '{13'h0020, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h0020, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h1001, 1'b0, 1'b0, 1'b0, 1'b1},
      '{13'h0000, 1'b1, 1'b1, 1'b1, 1'b0},
      '{13'h0080, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h0080, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h0118, 1'b0, 1'b0, 1'b0, 1'b1},
      '{13'h1000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{13'h1000, 1'b1, 1'b0, 1'b0, 1'b0}};

   always #5 clk = ~clk;

   always_comb begin
      linhas = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!colunas[c] && held[4*c+r]) linhas[r] = 1'b0;
         end
      end
   end

   varredor_teclado #(
      .DWELL_CYCLES  (DWELL),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .i_clock               (clk),
      .i_reset               (rst),
      .i_linhas              (linhas),
      .o_colunas             (colunas),
      .o_botoes              (botoes),
      .o_left_arrow_pressed  (left_p),
      .o_right_arrow_pressed (right_p),
      .o_enter_pressed       (enter_p),
      .o_multi_nota          (multi),
      .o_varredura_fim       (fim),
      .o_db_coluna           (db_col)
   );

   // Monitor: every publish pulse pops one expected snapshot; between pulses the
   // key outputs must hold still.
   initial begin
      int   since;
      exp_t cur;
      exp_t prev;
      exp_t e;
      logic prev_rst;
      since    = -1;
      prev     = '0;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         cur = {botoes, left_p, right_p, enter_p, multi};
         if (rst) begin
            since = -1;
         end else begin
            since++;
            if (fim) begin
               checks++;
               if (since != FRAME) begin
                  errors++;
                  $display("FAIL period: got %0d cycles, want %0d", since, FRAME);
               end
               since = 0;
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL publish: unexpected pulse, outputs %h", cur);
               end else begin
                  e = q.pop_front();
                  if (cur !== e) begin
                     errors++;
                     $display("FAIL snapshot: got botoes=%h l=%b r=%b e=%b m=%b, want botoes=%h l=%b r=%b e=%b m=%b",
                              cur.b, cur.l, cur.r, cur.e, cur.m, e.b, e.l, e.r, e.e, e.m);
                  end
               end
            end else if (!prev_rst) begin
               checks++;
               if (cur !== prev) begin
                  errors++;
                  $display("FAIL hold: outputs changed without pulse, got %h, was %h", cur, prev);
               end
            end
         end
         prev     = cur;
         prev_rst = rst;
      end
   end

   task automatic wait_fim(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fim && n < 200);
      if (!fim) begin
         checks++;
         errors++;
         $display("FAIL timeout: no varredura_fim within %0d cycles", n);
      end
   endtask

   task automatic check4(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   initial begin
      int          n;
      logic [3:0]  one;
      logic [3:0]  exp_col;
      one  = 4'b0001;
      held = t_mask[0];
      q.push_back(t_exp[0]);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k <= 34; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 0 || k == 33) exp_col = 4'b1111;
         else                   exp_col = ~(one << (((k - 1) % 33) / 8));
         check4($sformatf("colunas cycle %0d", k), {12'h0, colunas}, {12'h0, exp_col});
         check4($sformatf("fim cycle %0d", k), {15'h0, fim}, {15'h0, (k == 33)});
         if (k == 0) begin
            check4("reset outputs", {botoes, left_p, right_p, enter_p},
                   16'h0000);
            check4("reset multi/db", {13'h0, multi, db_col}, 16'h0000);
         end
      end

      held = t_mask[1];
      q.push_back(t_exp[1]);
      for (int i = 2; i < NF; i++) begin
         wait_fim(n);
         held = t_mask[i];
         q.push_back(t_exp[i]);
      end
      wait_fim(n);

      held = 16'h0200;
      n = 0;
      while (db_col != 2'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check4("reach column 2", {14'h0, db_col}, 16'h0002);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check4("midframe reset colunas", {12'h0, colunas}, 16'h000F);
      check4("midframe reset outputs", {botoes, left_p, right_p, enter_p}, 16'h0000);
      check4("midframe reset db/fim/multi", {12'h0, db_col, fim, multi}, 16'h0000);
      q.push_back('{13'h0200, 1'b0, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;
      wait_fim(n);
      check4("first publish after reset", n[15:0], 16'(FRAME));

      repeat (3) @(negedge clk);
      check4("scoreboard drained", 16'(q.size()), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
